// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-RAM access unit.
package mem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 32;
  localparam int REG_ADDR_W     = 5;
  localparam int INSTR_W        = 32;

endpackage : mem_pkg

// File: rtl/mem_wb_result_reg.sv
// MEM/WB result register: loads on load_en_i, injects a write-enable bubble on bubble_i,
// otherwise holds. Asynchronous active-low reset clears every field.
module mem_wb_result_reg
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en_i,
  input  logic                  bubble_i,
  input  logic [INSTR_W-1:0]    instr_i,
  input  logic                  regwrite_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  output logic [INSTR_W-1:0]    instr_o,
  output logic                  regwrite_o,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic [31:0]           wdata_o
);

  logic [INSTR_W-1:0]    instr_q;
  logic                  regwrite_q;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic [31:0]           wdata_q;

  // A bubble only clears the write enable; the payload fields keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else if (bubble_i) begin
      regwrite_q <= 1'b0;
    end else if (load_en_i) begin
      instr_q    <= instr_i;
      regwrite_q <= regwrite_i;
      waddr_q    <= waddr_i;
      wdata_q    <= wdata_i;
    end
  end

  assign instr_o    = instr_q;
  assign regwrite_o = regwrite_q;
  assign waddr_o    = waddr_q;
  assign wdata_o    = wdata_q;

endmodule : mem_wb_result_reg

// File: rtl/mem_stage_access_unit.sv
// MEM stage: data-RAM req/ack handshake, pipeline stall request and MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN suppresses and flags word-misaligned accesses.
module mem_stage_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_en,
  input  logic [INSTR_W-1:0]     mem_instruction,
  input  logic                   mem_ifWriteRegsFile,
  input  logic                   mem_memOutOrAluOutWriteBackToRegFile,
  input  logic                   mem_ifWriteMem,
  input  logic [REG_ADDR_W-1:0]  mem_registerWriteAddress,
  input  logic [31:0]            mem_aluOutput,
  input  logic [31:0]            mem_writeDataToDataRAM,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [ADDR_W-1:0]      dmem_addr,
  output logic [DATA_W-1:0]      dmem_wdata,
  input  logic [DATA_W-1:0]      dmem_rdata,
  input  logic                   dmem_ack,
  output logic                   mem_stall,
  output logic [INSTR_W-1:0]     wb_instruction,
  output logic                   wb_ifWriteRegsFile,
  output logic [REG_ADDR_W-1:0]  wb_registerWriteAddress,
  output logic [31:0]            wb_writeData,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   align_fault
);

  mem_state_e            state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic                  access;
  logic                  misaligned;
  logic                  issue;
  logic                  wb_load_en;
  logic [31:0]           wb_data_sel;

  assign access = cpu_en & (mem_ifWriteMem | mem_memOutOrAluOutWriteBackToRegFile);

`ifdef MEM_ALIGN_CHECK_EN
  logic align_fault_q;

  assign misaligned = access & (mem_aluOutput[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      align_fault_q <= 1'b0;
    end else begin
      align_fault_q <= misaligned;
    end
  end

  assign align_fault = align_fault_q;
`else
  assign misaligned  = 1'b0;
  assign align_fault = 1'b0;
`endif

  assign issue = access & ~misaligned;

  // Once in WAIT the request is held regardless of cpu_en so an issued access always completes.
  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          dmem_req = 1'b1;
          if (!dmem_ack) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign dmem_we    = mem_ifWriteMem;
  assign dmem_addr  = mem_aluOutput[ADDR_W-1:0];
  assign dmem_wdata = DATA_W'(mem_writeDataToDataRAM);

  // Stall drops in the ack cycle so EX/MEM advances on that edge and the access is not reissued.
  assign mem_stall = dmem_req & ~dmem_ack;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (mem_stall) begin
      stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

  assign wb_load_en  = cpu_en & ~mem_stall;
  assign wb_data_sel = mem_memOutOrAluOutWriteBackToRegFile ? 32'(dmem_rdata) : mem_aluOutput;

  mem_wb_result_reg u_wb_reg (
    .clk        (clk),
    .rst_n      (rst),
    .load_en_i  (wb_load_en),
    .bubble_i   (mem_stall),
    .instr_i    (mem_instruction),
    .regwrite_i (mem_ifWriteRegsFile & ~misaligned),
    .waddr_i    (mem_registerWriteAddress),
    .wdata_i    (wb_data_sel),
    .instr_o    (wb_instruction),
    .regwrite_o (wb_ifWriteRegsFile),
    .waddr_o    (wb_registerWriteAddress),
    .wdata_o    (wb_writeData)
  );

endmodule : mem_stage_access_unit

// File: tb/tb_mem_stage_access_unit.sv
// Directed self-checking bench for mem_stage_access_unit; inputs change on the falling edge,
// combinational outputs are checked before the rising edge, registered ones 1ns after it.
module tb_mem_stage_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_en;
  logic [31:0] mem_instruction;
  logic        mem_ifWriteRegsFile;
  logic        mem_load;
  logic        mem_ifWriteMem;
  logic [4:0]  mem_registerWriteAddress;
  logic [31:0] mem_aluOutput;
  logic [31:0] mem_writeDataToDataRAM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall;
  logic [31:0] wb_instruction;
  logic        wb_ifWriteRegsFile;
  logic [4:0]  wb_registerWriteAddress;
  logic [31:0] wb_writeData;
  logic [31:0] stall_cycles;
  logic        align_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_access_unit dut (
    .clk                                  (clk),
    .rst                                  (rst_n),
    .cpu_en                               (cpu_en),
    .mem_instruction                      (mem_instruction),
    .mem_ifWriteRegsFile                  (mem_ifWriteRegsFile),
    .mem_memOutOrAluOutWriteBackToRegFile (mem_load),
    .mem_ifWriteMem                       (mem_ifWriteMem),
    .mem_registerWriteAddress             (mem_registerWriteAddress),
    .mem_aluOutput                        (mem_aluOutput),
    .mem_writeDataToDataRAM               (mem_writeDataToDataRAM),
    .dmem_req                             (dmem_req),
    .dmem_we                              (dmem_we),
    .dmem_addr                            (dmem_addr),
    .dmem_wdata                           (dmem_wdata),
    .dmem_rdata                           (dmem_rdata),
    .dmem_ack                             (dmem_ack),
    .mem_stall                            (mem_stall),
    .wb_instruction                       (wb_instruction),
    .wb_ifWriteRegsFile                   (wb_ifWriteRegsFile),
    .wb_registerWriteAddress              (wb_registerWriteAddress),
    .wb_writeData                         (wb_writeData),
    .stall_cycles                         (stall_cycles),
    .align_fault                          (align_fault)
  );

  task automatic drive(input logic en, input logic [31:0] instr, input logic rw, input logic ld,
                       input logic st, input logic [4:0] wa, input logic [31:0] alu,
                       input logic [31:0] sd, input logic ack, input logic [31:0] rd);
    cpu_en                   = en;
    mem_instruction          = instr;
    mem_ifWriteRegsFile      = rw;
    mem_load                 = ld;
    mem_ifWriteMem           = st;
    mem_registerWriteAddress = wa;
    mem_aluOutput            = alu;
    mem_writeDataToDataRAM   = sd;
    dmem_ack                 = ack;
    dmem_rdata               = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (wb_instruction !== 32'h0 || wb_ifWriteRegsFile !== 1'b0 ||
        wb_registerWriteAddress !== 5'd0 || wb_writeData !== 32'h0) begin
      errors++;
      $display("FAIL reset_wb: instr=%h rw=%b wa=%0d wd=%h required all zero",
               wb_instruction, wb_ifWriteRegsFile, wb_registerWriteAddress, wb_writeData);
    end
    checks++;
    if (stall_cycles !== 32'd0 || align_fault !== 1'b0 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: stall_cycles=%0d align_fault=%b req=%b stall=%b required 0/0/0/0",
               stall_cycles, align_fault, dmem_req, mem_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_alu_passthrough();
    @(negedge clk);
    drive(1'b1, 32'h00A0_0093, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_no_req: req=%b stall=%b required 0/0", dmem_req, mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wb_writeData !== 32'h0000_1234 || wb_ifWriteRegsFile !== 1'b1 ||
        wb_registerWriteAddress !== 5'd5 || wb_instruction !== 32'h00A0_0093) begin
      errors++;
      $display("FAIL alu_wb: wd=%h rw=%b wa=%0d instr=%h required 00001234/1/5/00a00093",
               wb_writeData, wb_ifWriteRegsFile, wb_registerWriteAddress, wb_instruction);
    end
    $display("alu: addr=0x1234 wb_writeData=%h", wb_writeData);
  endtask

  task automatic test_load_wait();
    int stall_seen = 0;
    int ack_pairs  = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h1000_2383, 1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_0100, 32'h0,
            (i == 3), (i == 3) ? 32'hDEAD_BEEF : 32'h0);
      #1;
      if (mem_stall === 1'b1) stall_seen++;
      if (dmem_req === 1'b1 && dmem_ack === 1'b1) ack_pairs++;
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 || mem_stall !== (i < 3)) begin
        errors++;
        $display("FAIL load_cycle%0d: req=%b we=%b addr=%h stall=%b required 1/0/00000100/%b",
                 i, dmem_req, dmem_we, dmem_addr, mem_stall, (i < 3));
      end
      if (i == 1) begin
        checks++;
        if (wb_ifWriteRegsFile !== 1'b0) begin
          errors++;
          $display("FAIL load_bubble: wb_ifWriteRegsFile=%b required 0", wb_ifWriteRegsFile);
        end
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (wb_writeData !== 32'hDEAD_BEEF || wb_ifWriteRegsFile !== 1'b1 || wb_registerWriteAddress !== 5'd7) begin
      errors++;
      $display("FAIL load_wb: wd=%h rw=%b wa=%0d required deadbeef/1/7",
               wb_writeData, wb_ifWriteRegsFile, wb_registerWriteAddress);
    end
    checks++;
    if (stall_cycles !== 32'd3 || stall_seen != 3) begin
      errors++;
      $display("FAIL load_stall_count: stall_cycles=%0d observed=%0d required 3", stall_cycles, stall_seen);
    end
    @(negedge clk);
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    if (dmem_req === 1'b1) ack_pairs++;
    checks++;
    if (ack_pairs != 1) begin
      errors++;
      $display("FAIL load_single_pair: req/ack pairs=%0d required 1", ack_pairs);
    end
    $display("load: addr=0x100 wb_writeData=%h stall_cycles=%0d", wb_writeData, stall_cycles);
  endtask

  task automatic test_store_zero_wait();
    @(negedge clk);
    drive(1'b1, 32'h20A0_2023, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0200, 32'hCAFE_0001, 1'b1, 32'h0);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || mem_stall !== 1'b0 ||
        dmem_addr !== 32'h200 || dmem_wdata !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL store_req: req=%b we=%b stall=%b addr=%h wdata=%h required 1/1/0/00000200/cafe0001",
               dmem_req, dmem_we, mem_stall, dmem_addr, dmem_wdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wb_ifWriteRegsFile !== 1'b0 || wb_writeData !== 32'h200 || stall_cycles !== 32'd3) begin
      errors++;
      $display("FAIL store_wb: rw=%b wd=%h stall_cycles=%0d required 0/00000200/3",
               wb_ifWriteRegsFile, wb_writeData, stall_cycles);
    end
    $display("store: addr=0x200 data=cafe0001 stall_cycles=%0d", stall_cycles);
  endtask

  task automatic test_ack_without_req();
    @(negedge clk);
    drive(1'b1, 32'h0050_0113, 1'b1, 1'b0, 1'b0, 5'd2, 32'h0000_0050, 32'h0, 1'b1, 32'h1111_2222);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack_req: req=%b stall=%b required 0/0", dmem_req, mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wb_writeData !== 32'h50 || wb_ifWriteRegsFile !== 1'b1 || wb_registerWriteAddress !== 5'd2) begin
      errors++;
      $display("FAIL stray_ack_wb: wd=%h rw=%b wa=%0d required 00000050/1/2",
               wb_writeData, wb_ifWriteRegsFile, wb_registerWriteAddress);
    end
    $display("stray_ack: wb_writeData=%h", wb_writeData);
  endtask

  task automatic test_cpu_en_hold();
    @(negedge clk);
    drive(1'b0, 32'h3000_2403, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0300, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_req: req=%b stall=%b required 0/0", dmem_req, mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wb_writeData !== 32'h50 || wb_ifWriteRegsFile !== 1'b1 || wb_registerWriteAddress !== 5'd2 ||
        wb_instruction !== 32'h0050_0113 || stall_cycles !== 32'd3) begin
      errors++;
      $display("FAIL hold_wb: wd=%h rw=%b wa=%0d instr=%h sc=%0d required 00000050/1/2/00500113/3",
               wb_writeData, wb_ifWriteRegsFile, wb_registerWriteAddress, wb_instruction, stall_cycles);
    end
    $display("cpu_en_hold: wb_writeData=%h stall_cycles=%0d", wb_writeData, stall_cycles);
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    drive(1'b1, 32'h3000_2403, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0300, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    checks++;
    if (mem_stall !== 1'b1 || stall_cycles !== 32'd4) begin
      errors++;
      $display("FAIL rst_wait_entry: stall=%b sc=%0d required 1/4", mem_stall, stall_cycles);
    end
    @(negedge clk);
    rst_n  = 1'b0;
    cpu_en = 1'b0;
    #1;
    checks++;
    if (wb_instruction !== 32'h0 || wb_ifWriteRegsFile !== 1'b0 || wb_registerWriteAddress !== 5'd0 ||
        wb_writeData !== 32'h0 || stall_cycles !== 32'd0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_wait: instr=%h rw=%b wa=%0d wd=%h sc=%0d req=%b required all 0",
               wb_instruction, wb_ifWriteRegsFile, wb_registerWriteAddress, wb_writeData,
               stall_cycles, dmem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h0550_0193, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0000_0055, 32'h0, 1'b1, 32'h0BAD_0BAD);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_req: req=%b stall=%b required 0/0", dmem_req, mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wb_writeData !== 32'h55 || wb_ifWriteRegsFile !== 1'b0 || stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL late_ack_wb: wd=%h rw=%b sc=%0d required 00000055/0/0",
               wb_writeData, wb_ifWriteRegsFile, stall_cycles);
    end
    $display("reset_mid_wait: wb_writeData=%h stall_cycles=%0d", wb_writeData, stall_cycles);
  endtask

  task automatic test_misaligned();
    @(negedge clk);
`ifdef MEM_ALIGN_CHECK_EN
    drive(1'b1, 32'h1020_2283, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_0102, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL align_no_req: req=%b stall=%b required 0/0", dmem_req, mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (align_fault !== 1'b1 || wb_ifWriteRegsFile !== 1'b0) begin
      errors++;
      $display("FAIL align_pulse: align_fault=%b rw=%b required 1/0", align_fault, wb_ifWriteRegsFile);
    end
    @(negedge clk);
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    checks++;
    if (align_fault !== 1'b0) begin
      errors++;
      $display("FAIL align_pulse_end: align_fault=%b required 0", align_fault);
    end
`else
    drive(1'b1, 32'h1020_2283, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_0102, 32'h0, 1'b1, 32'h1357_9BDF);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h102 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL unaligned_req: req=%b addr=%h stall=%b required 1/00000102/0",
               dmem_req, dmem_addr, mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wb_writeData !== 32'h1357_9BDF || wb_ifWriteRegsFile !== 1'b1 || align_fault !== 1'b0) begin
      errors++;
      $display("FAIL unaligned_wb: wd=%h rw=%b align_fault=%b required 13579bdf/1/0",
               wb_writeData, wb_ifWriteRegsFile, align_fault);
    end
`endif
    $display("misaligned: addr=0x102 align_fault=%b wb_ifWriteRegsFile=%b", align_fault, wb_ifWriteRegsFile);
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    test_load_wait();
    test_store_zero_wait();
    test_ack_without_req();
    test_cpu_en_hold();
    test_reset_mid_wait();
    test_misaligned();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_stage_access_unit
